// File: rtl/ifetch_buf.sv
// Single-entry instruction fetch buffer sitting between data_path and instruction memory.
// A hit returns the buffered word combinationally; a miss issues one registered request and stalls.
module ifetch_buf #(
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  output logic        fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t      state_reg, state_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [29:0] buf_tag_reg, buf_tag_next;
  logic [31:0] buf_data_reg, buf_data_next;
  logic        mem_req_reg, mem_req_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        hit;

  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
      buf_data_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_tag_reg   <= buf_tag_next;
      buf_data_reg  <= buf_data_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    hit            = buf_valid_reg && (pc[1:0] == 2'b00) && (pc[31:2] == buf_tag_reg);
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg;
    buf_tag_next   = buf_tag_reg;
    buf_data_next  = buf_data_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    cnt_next       = cnt_reg;
    instr          = NOP_INSTR;
    stall          = 1'b1;
    fault          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (hit) begin
          instr = buf_data_reg;
          stall = 1'b0;
        end else if (pc[1:0] != 2'b00) begin
          state_next = ERR;
        end else begin
          mem_req_next  = 1'b1;
          mem_addr_next = {pc[31:2], 2'b00};
          cnt_next      = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        // The latched request owns this state; pc is not looked at until IDLE.
        if (mem_ack) begin
          buf_data_next  = mem_rdata;
          buf_tag_next   = mem_addr_reg[31:2];
          buf_valid_next = 1'b1;
          mem_req_next   = 1'b0;
          state_next     = IDLE;
        end else if (cnt_reg == TIMEOUT) begin
          mem_req_next = 1'b0;
          state_next   = ERR;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ERR: begin
        fault = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf: a transaction-level model of buffer/request/fault
// is checked every cycle, and directed sequences pin latencies and literal values.
module tb_ifetch_buf;
  localparam logic [31:0] NOP = 32'hE1A00000;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr;
  logic        stall, fault, mem_req;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_ack;
  logic        auto_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_lat = 1;
  int          wcnt = 0;
  bit          cmp_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A03002;
    return (a * 32'd3) + 32'h1000_0001;
  endfunction

  assign mem_ack   = auto_ack | stray_ack;
  assign mem_rdata = mem_word(mem_addr);

  ifetch_buf #(.NOP_INSTR(NOP), .TIMEOUT(8'(TO))) dut (
    .clk(clk), .reset(rst), .pc(pc), .instr(instr), .stall(stall), .fault(fault),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after ack_lat cycles of visible request (0 = never).
  always @(posedge clk) begin
    #1;
    if (mem_req && !rst) begin
      wcnt++;
      auto_ack = (ack_lat != 0) && (wcnt >= ack_lat);
    end else begin
      wcnt = 0;
      auto_ack = 1'b0;
    end
  end

  // Model: buffered word, outstanding request with its age, sticky fault.
  logic        m_valid = 1'b0, m_pend = 1'b0, m_fault = 1'b0;
  logic [31:0] m_addr = 32'h0, m_data = 32'h0, m_paddr = 32'h0;
  int          m_age = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_pend <= 1'b0; m_fault <= 1'b0;
      m_addr <= 32'h0; m_data <= 32'h0; m_age <= 0;
    end else if (!m_fault) begin
      if (m_pend) begin
        if (mem_ack) begin
          m_valid <= 1'b1; m_addr <= m_paddr; m_data <= mem_word(m_paddr); m_pend <= 1'b0;
        end else if (m_age == TO) begin
          m_fault <= 1'b1; m_pend <= 1'b0;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (!(m_valid && pc == m_addr)) begin
        if (pc[1:0] != 2'b00) m_fault <= 1'b1;
        else begin m_pend <= 1'b1; m_paddr <= pc; m_age <= 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      automatic logic exp_hit = !rst && !m_fault && !m_pend && m_valid && (pc == m_addr);
      check("stall", 32'(stall), 32'(!exp_hit));
      check("instr", instr, exp_hit ? m_data : NOP);
      check("fault", 32'(fault), 32'(m_fault));
      check("mem_req", 32'(mem_req), 32'(m_pend));
      if (m_pend) check("mem_addr", mem_addr, m_paddr);
    end
  end

  task automatic measure(input int exp_stall, input logic [31:0] exp_addr);
    int n = 0;
    logic [31:0] a = 32'h0;
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (mem_req) begin
        if (seen) check("req_hold", mem_addr, a);
        a = mem_addr;
        seen = 1'b1;
      end else begin
        seen = 1'b0;
      end
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    check("fetch_addr", a, exp_addr);
    check("fetch_instr", instr, mem_word(exp_addr));
    $display("fetch pc=%h stall_cycles=%0d addr=%h instr=%h", pc, n, a, instr);
  endtask

  task automatic fetch(input logic [31:0] p, input int lat, input int exp_stall);
    @(posedge clk); #1;
    pc = p;
    ack_lat = lat;
    measure(exp_stall, p);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'h1);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ack_lat = 1;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'h1);
    check("rst_instr", instr, NOP);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // First fetch after reset release, ack in first WAIT cycle
    @(posedge clk); #1; rst = 1'b0;
    measure(2, 32'h0);
    check("first_word", instr, 32'hE3A03002);

    // Held pc: no further requests
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_req", 32'(mem_req), 32'h0);
      check("hold_instr", instr, 32'hE3A03002);
    end

    // Three-cycle memory latency
    fetch(32'h4, 3, 4);
    fetch(32'h8, 3, 4);

    // Stray ack while hitting must not disturb the buffer
    @(posedge clk); #1; stray_ack = 1'b1;
    @(posedge clk); #1; stray_ack = 1'b0;
    @(negedge clk);
    check("stray_hit_instr", instr, mem_word(32'h8));
    check("stray_hit_stall", 32'(stall), 32'h0);

    // pc moves during WAIT: 12 completes first, then 16 is fetched
    @(posedge clk); #1; pc = 32'hC; ack_lat = 3;
    @(posedge clk); #1; pc = 32'h10;
    measure(7, 32'h10);

    // Reset during WAIT abandons the request; stray ack afterwards is ignored
    @(posedge clk); #1; pc = 32'h14; ack_lat = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; stray_ack = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 32'h1);
    check("post_rst_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1; stray_ack = 1'b0;
    @(negedge clk);
    check("reissue_req", 32'(mem_req), 32'h1);
    check("reissue_addr", mem_addr, 32'h14);
    ack_lat = 1;
    repeat (3) @(negedge clk);
    check("reissue_instr", instr, mem_word(32'h14));
    check("reissue_stall", 32'(stall), 32'h0);

    // Misaligned pc -> sticky fault
    @(posedge clk); #1; pc = 32'h6;
    @(negedge clk);
    check("misal_cycle0_fault", 32'(fault), 32'h0);
    check("misal_cycle0_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) stray_ack = 1'b1;
      check("misal_fault", 32'(fault), 32'h1);
      check("misal_stall", 32'(stall), 32'h1);
      check("misal_req", 32'(mem_req), 32'h0);
      check("misal_instr", instr, NOP);
    end
    stray_ack = 1'b0;
    pulse_reset();

    // Timeout: no ack at all
    pc = 32'h40; ack_lat = 0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fault) break;
      if (mem_req) n++;
    end
    check("timeout_wait_cycles", 32'(n), 32'(TO + 1));
    check("timeout_fault", 32'(fault), 32'h1);
    check("timeout_req", 32'(mem_req), 32'h0);
    $display("timeout pc=%h wait_cycles=%0d fault=%0d", pc, n, fault);
    pulse_reset();

    // Ack on the last permitted edge wins over the timeout
    ack_lat = TO + 1;
    measure(TO + 2, 32'h40);
    check("late_ack_fault", 32'(fault), 32'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
